// File: rtl/rx_handshake_if.sv
// rtl/rx_handshake_if.sv - request/ack and event-pop signal bundle for rx_handshake
// The slave side is the receiver; the master side is the sender plus event consumer.
interface rx_handshake_if #(
  parameter int CW = 4
) ();
  logic          req_in;
  logic          ack_out;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] pending;
  logic          rx_busy;
  logic          proto_err;

  modport master (
    output req_in,
    output evt_ready,
    input  ack_out,
    input  evt_valid,
    input  pending,
    input  rx_busy,
    input  proto_err
  );

  modport slave (
    input  req_in,
    input  evt_ready,
    output ack_out,
    output evt_valid,
    output pending,
    output rx_busy,
    output proto_err
  );
endinterface

// File: rtl/rx_handshake.sv
// rtl/rx_handshake.sv - four-phase ack receiver banking requests into a credit counter
// Accepted requests become pending events released through a valid/ready pop port.
module rx_handshake #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 15,
  parameter int CW          = 4,
  parameter int TIMEOUT     = 255,
  parameter int TW          = 8
) (
  input logic         clk,
  input logic         rst,
  rx_handshake_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_HIGH = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q, ack_d;
  logic [CW-1:0]          pending_q, pending_d;
  logic [TW-1:0]          timer_q, timer_d, timer_inc;
  logic                   accept;
  logic                   pop;
  logic                   evt_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
    end
  end

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign evt_valid = (pending_q != '0);
  assign pop       = evt_valid & bus.evt_ready;
  assign timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Space is judged on the registered count; a same-cycle pop frees it next cycle.
        if (req_s && (pending_q < CW'(DEPTH))) begin
          accept  = 1'b1;
          state_d = ACK_HIGH;
        end
      end
      ACK_HIGH: begin
        timer_d = timer_inc;
        if (!req_s) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (timer_inc == TW'(TIMEOUT))) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    ack_d     = (state_d == ACK_HIGH);
    pending_d = pending_q;
    if (accept && !pop) begin
      pending_d = pending_q + CW'(1);
    end else if (!accept && pop) begin
      pending_d = pending_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.ack_out   = ack_q;
  assign bus.evt_valid = evt_valid;
  assign bus.pending   = pending_q;
  assign bus.rx_busy   = (state_q != IDLE);
  assign bus.proto_err = (state_q == ERR);

endmodule
